// File: rtl/dec_inst_queue.sv
// Decode-to-rename instruction queue: circular buffer with wrap-bit pointers,
// group enqueue, and a dequeue window that honours serializing instructions.
package dec_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        need_serialize;
    } decInfo_t;
endpackage

module dec_inst_queue
    import dec_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ENQ_WIDTH = 4,
    parameter int DEQ_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_squash,
    input  logic [ENQ_WIDTH-1:0]     i_enq_vld,
    input  decInfo_t [ENQ_WIDTH-1:0] i_enq_inst,
    output logic                     o_enq_rdy,
    output logic [DEQ_WIDTH-1:0]     o_deq_vld,
    output decInfo_t [DEQ_WIDTH-1:0] o_deq_inst,
    input  logic                     i_deq_rdy,
    input  logic                     i_rob_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] enq_cnt, deq_cnt;
    logic [AW-1:0] head_idx, tail_idx;
    logic          enq_fire, deq_fire;
    decInfo_t      mem_q [DEPTH];

    assign head_idx = head_q[AW-1:0];
    assign tail_idx = tail_q[AW-1:0];

    // Pointer difference modulo 2*DEPTH: full is same index, opposite wrap bit.
    assign o_count   = tail_q - head_q;
    assign o_enq_rdy = o_count <= PW'(DEPTH - ENQ_WIDTH);

    always_comb begin : deq_window
        logic     stop;
        decInfo_t ent;
        stop      = 1'b0;
        o_deq_vld = '0;
        for (int k = 0; k < DEQ_WIDTH; k++) begin
            ent           = mem_q[head_idx + AW'(k)];
            o_deq_inst[k] = ent;
            if (!stop) begin
                if (o_count <= PW'(k)) begin
                    stop = 1'b1;
                end else if (ent.need_serialize) begin
                    // A serializer issues alone, and only once the ROB drains.
                    if (k == 0) o_deq_vld[0] = i_rob_empty;
                    stop = 1'b1;
                end else begin
                    o_deq_vld[k] = 1'b1;
                end
            end
        end
        if (i_squash) o_deq_vld = '0;
    end

    always_comb begin
        enq_cnt = '0;
        deq_cnt = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) enq_cnt += PW'(i_enq_vld[i]);
        for (int k = 0; k < DEQ_WIDTH; k++) deq_cnt += PW'(o_deq_vld[k]);
    end

    assign enq_fire = o_enq_rdy & (|i_enq_vld) & ~i_squash;
    assign deq_fire = i_deq_rdy & (|o_deq_vld) & ~i_squash;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (i_squash) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + enq_cnt;
            if (deq_fire) head_d = head_q + deq_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (enq_fire && i_enq_vld[i]) begin
                mem_q[tail_idx + AW'(i)] <= i_enq_inst[i];
            end
        end
    end

    logic [ENQ_WIDTH-1:0] enq_vld_inc;
    assign enq_vld_inc = i_enq_vld + ENQ_WIDTH'(1);

    a_enq_contig: assert property (
        @(posedge clk) disable iff (!rst)
        (i_enq_vld & enq_vld_inc) == '0
    ) else $error("non-contiguous i_enq_vld %b", i_enq_vld);

endmodule

// File: tb/tb_dec_inst_queue.sv
// Scenario bench for dec_inst_queue: a scoreboard queue tracks accepted
// entries in order and is popped as rename consumes them.
module tb_dec_inst_queue;
    import dec_pkg::*;

    localparam int DEPTH = 8;
    localparam int EW    = 4;
    localparam int DW    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_squash;
    logic [EW-1:0]     i_enq_vld;
    decInfo_t [EW-1:0] i_enq_inst;
    logic              o_enq_rdy;
    logic [DW-1:0]     o_deq_vld;
    decInfo_t [DW-1:0] o_deq_inst;
    logic              i_deq_rdy;
    logic              i_rob_empty;
    logic [3:0]        o_count;

    int       ntest = 0;
    int       nfail = 0;
    int       seq = 0;
    int       m_cnt = 0;
    int       pend_deq = 0;
    decInfo_t sb [$];

    dec_inst_queue #(.DEPTH(DEPTH), .ENQ_WIDTH(EW), .DEQ_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .i_squash(i_squash),
        .i_enq_vld(i_enq_vld), .i_enq_inst(i_enq_inst),
        .o_enq_rdy(o_enq_rdy), .o_deq_vld(o_deq_vld),
        .o_deq_inst(o_deq_inst), .i_deq_rdy(i_deq_rdy),
        .i_rob_empty(i_rob_empty), .o_count(o_count)
    );

    always #5 clk = ~clk;

    // Drive a contiguous group of n fresh entries; ser marks a serializing slot.
    task automatic set_enq(input int n, input int ser);
        decInfo_t e;
        i_enq_vld = '0;
        for (int k = 0; k < EW; k++) begin
            if (k < n) begin
                i_enq_vld[k]     = 1'b1;
                e.pc             = 32'h1000 + 32'(seq) * 4;
                e.inst           = 32'hC0DE_0000 + 32'(seq);
                e.need_serialize = (k == ser);
                i_enq_inst[k]    = e;
                seq++;
            end else begin
                i_enq_inst[k] = '0;
            end
        end
    endtask

    // Advance one edge; the model accepts a group only from the registered count.
    task automatic tick();
        int e = 0;
        if (!i_squash && m_cnt <= DEPTH - EW && i_enq_vld != '0) begin
            for (int k = 0; k < EW; k++) begin
                if (i_enq_vld[k]) begin
                    sb.push_back(i_enq_inst[k]);
                    e++;
                end
            end
        end
        @(posedge clk);
        if (i_squash) begin
            sb.delete();
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + e - pend_deq;
        end
        pend_deq = 0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        i_squash = 1'b0;
        i_enq_vld = '0;
        i_enq_inst = '0;
        i_deq_rdy = 1'b0;
        i_rob_empty = 1'b0;
        sb.delete();
        m_cnt = 0;
        pend_deq = 0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        i_squash = 1'b0;
        i_enq_vld = '0;
        i_enq_inst = '0;
        i_deq_rdy = 1'b0;
        i_rob_empty = 1'b0;
        #1;
        ntest++;
        if (o_count !== 4'd0 || o_deq_vld !== 4'b0 || o_enq_rdy !== 1'b1) begin
            nfail++;
            $display("FAIL reset: count=%0d vld=%b rdy=%b, want 0 0000 1",
                     o_count, o_deq_vld, o_enq_rdy);
        end
        #1;
        rst = 1'b1;
        tick();
        ntest++;
        if (o_count !== 4'd0 || o_deq_vld !== 4'b0) begin
            nfail++;
            $display("FAIL reset_release: count=%0d vld=%b, want 0 0000",
                     o_count, o_deq_vld);
        end
    endtask

    task automatic test_basic();
        decInfo_t x;
        do_reset();
        set_enq(4, -1);
        tick();
        set_enq(0, -1);
        #1;
        ntest++;
        if (o_count !== 4'd4 || o_deq_vld !== 4'b1111 || o_enq_rdy !== 1'b1) begin
            nfail++;
            $display("FAIL basic_state: count=%0d vld=%b rdy=%b, want 4 1111 1",
                     o_count, o_deq_vld, o_enq_rdy);
        end
        for (int k = 0; k < DW; k++) begin
            ntest++;
            if (o_deq_inst[k] !== sb[k]) begin
                nfail++;
                $display("FAIL basic_order[%0d]: got %h want %h",
                         k, o_deq_inst[k], sb[k]);
            end
        end
        i_deq_rdy = 1'b1;
        #1;
        for (int k = 0; k < DW; k++) begin
            if (o_deq_vld[k] && sb.size() > 0) begin
                x = sb.pop_front();
                pend_deq++;
                ntest++;
                if (o_deq_inst[k] !== x) begin
                    nfail++;
                    $display("FAIL basic_deq[%0d]: got %h want %h",
                             k, o_deq_inst[k], x);
                end
            end
        end
        tick();
        tick();
        ntest++;
        if (o_count !== 4'd0 || o_deq_vld !== 4'b0 || m_cnt != 0) begin
            nfail++;
            $display("FAIL basic_empty: count=%0d vld=%b, want 0 0000",
                     o_count, o_deq_vld);
        end
        i_deq_rdy = 1'b0;
    endtask

    task automatic test_full();
        decInfo_t x;
        do_reset();
        set_enq(4, -1);
        tick();
        set_enq(4, -1);
        tick();
        ntest++;
        if (o_count !== 4'd8 || o_enq_rdy !== 1'b0) begin
            nfail++;
            $display("FAIL full_state: count=%0d rdy=%b, want 8 0",
                     o_count, o_enq_rdy);
        end
        set_enq(4, -1);
        tick();
        ntest++;
        if (o_count !== 4'd8) begin
            nfail++;
            $display("FAIL full_ignore: count=%0d, want 8", o_count);
        end
        i_deq_rdy = 1'b1;
        #1;
        for (int k = 0; k < DW; k++) begin
            if (o_deq_vld[k] && sb.size() > 0) begin
                x = sb.pop_front();
                pend_deq++;
                ntest++;
                if (o_deq_inst[k] !== x) begin
                    nfail++;
                    $display("FAIL full_deq[%0d]: got %h want %h",
                             k, o_deq_inst[k], x);
                end
            end
        end
        tick();
        i_deq_rdy = 1'b0;
        #1;
        ntest++;
        if (o_count !== 4'd4 || o_enq_rdy !== 1'b1) begin
            nfail++;
            $display("FAIL full_drain: count=%0d rdy=%b, want 4 1",
                     o_count, o_enq_rdy);
        end
        tick();
        set_enq(0, -1);
        ntest++;
        if (o_count !== 4'd8 || sb.size() != 8) begin
            nfail++;
            $display("FAIL full_accept: count=%0d sb=%0d, want 8 8",
                     o_count, sb.size());
        end
        ntest++;
        if (o_deq_inst[0] !== sb[0]) begin
            nfail++;
            $display("FAIL full_head: got %h want %h", o_deq_inst[0], sb[0]);
        end
    endtask

    task automatic test_serialize();
        decInfo_t x;
        do_reset();
        set_enq(4, 2);
        tick();
        set_enq(0, -1);
        #1;
        ntest++;
        if (o_deq_vld !== 4'b0011) begin
            nfail++;
            $display("FAIL ser_window: vld=%b, want 0011", o_deq_vld);
        end
        i_deq_rdy = 1'b1;
        #1;
        for (int k = 0; k < DW; k++) begin
            if (o_deq_vld[k] && sb.size() > 0) begin
                x = sb.pop_front();
                pend_deq++;
                ntest++;
                if (o_deq_inst[k] !== x) begin
                    nfail++;
                    $display("FAIL ser_deq[%0d]: got %h want %h",
                             k, o_deq_inst[k], x);
                end
            end
        end
        tick();
        i_deq_rdy = 1'b0;
        #1;
        ntest++;
        if (o_deq_vld !== 4'b0000 || o_count !== 4'd2) begin
            nfail++;
            $display("FAIL ser_wait: vld=%b count=%0d, want 0000 2",
                     o_deq_vld, o_count);
        end
        i_rob_empty = 1'b1;
        #1;
        ntest++;
        if (o_deq_vld !== 4'b0001 || o_deq_inst[0] !== sb[0]
            || o_deq_inst[0].need_serialize !== 1'b1) begin
            nfail++;
            $display("FAIL ser_alone: vld=%b inst=%h, want 0001 %h",
                     o_deq_vld, o_deq_inst[0], sb[0]);
        end
        i_deq_rdy = 1'b1;
        #1;
        for (int k = 0; k < DW; k++) begin
            if (o_deq_vld[k] && sb.size() > 0) begin
                x = sb.pop_front();
                pend_deq++;
                ntest++;
                if (o_deq_inst[k] !== x) begin
                    nfail++;
                    $display("FAIL ser_deq2[%0d]: got %h want %h",
                             k, o_deq_inst[k], x);
                end
            end
        end
        tick();
        i_deq_rdy = 1'b0;
        i_rob_empty = 1'b0;
        #1;
        ntest++;
        if (o_deq_vld !== 4'b0001 || o_count !== 4'd1) begin
            nfail++;
            $display("FAIL ser_tail: vld=%b count=%0d, want 0001 1",
                     o_deq_vld, o_count);
        end
    endtask

    task automatic test_wrap();
        decInfo_t x;
        do_reset();
        set_enq(4, -1);
        tick();
        i_deq_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            set_enq(4, -1);
            #1;
            ntest++;
            if (o_deq_vld !== 4'b1111) begin
                nfail++;
                $display("FAIL wrap_vld[%0d]: vld=%b, want 1111", c, o_deq_vld);
            end
            for (int k = 0; k < DW; k++) begin
                if (o_deq_vld[k] && sb.size() > 0) begin
                    x = sb.pop_front();
                    pend_deq++;
                    ntest++;
                    if (o_deq_inst[k] !== x) begin
                        nfail++;
                        $display("FAIL wrap_deq[%0d.%0d]: got %h want %h",
                                 c, k, o_deq_inst[k], x);
                    end
                end
            end
            tick();
            ntest++;
            if (o_count !== 4'd4) begin
                nfail++;
                $display("FAIL wrap_count[%0d]: count=%0d, want 4", c, o_count);
            end
        end
        set_enq(0, -1);
        i_deq_rdy = 1'b0;
    endtask

    task automatic test_squash();
        do_reset();
        set_enq(4, -1);
        tick();
        set_enq(2, -1);
        tick();
        ntest++;
        if (o_count !== 4'd6) begin
            nfail++;
            $display("FAIL squash_pre: count=%0d, want 6", o_count);
        end
        set_enq(4, -1);
        i_deq_rdy = 1'b1;
        i_squash = 1'b1;
        #1;
        ntest++;
        if (o_deq_vld !== 4'b0000) begin
            nfail++;
            $display("FAIL squash_vld: vld=%b, want 0000", o_deq_vld);
        end
        tick();
        i_squash = 1'b0;
        i_deq_rdy = 1'b0;
        set_enq(0, -1);
        #1;
        ntest++;
        if (o_count !== 4'd0 || o_enq_rdy !== 1'b1 || o_deq_vld !== 4'b0) begin
            nfail++;
            $display("FAIL squash_post: count=%0d rdy=%b vld=%b, want 0 1 0000",
                     o_count, o_enq_rdy, o_deq_vld);
        end
        set_enq(3, -1);
        tick();
        set_enq(0, -1);
        #1;
        ntest++;
        if (o_count !== 4'd3 || o_deq_vld !== 4'b0111 || o_deq_inst[0] !== sb[0]) begin
            nfail++;
            $display("FAIL squash_resume: count=%0d vld=%b, want 3 0111",
                     o_count, o_deq_vld);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_enq(4, -1);
        tick();
        set_enq(1, -1);
        tick();
        set_enq(0, -1);
        ntest++;
        if (o_count !== 4'd5) begin
            nfail++;
            $display("FAIL arst_pre: count=%0d, want 5", o_count);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        ntest++;
        if (o_count !== 4'd0 || o_deq_vld !== 4'b0 || o_enq_rdy !== 1'b1) begin
            nfail++;
            $display("FAIL arst_mid: count=%0d vld=%b rdy=%b, want 0 0000 1",
                     o_count, o_deq_vld, o_enq_rdy);
        end
        #1;
        rst = 1'b1;
        sb.delete();
        m_cnt = 0;
        set_enq(4, -1);
        tick();
        set_enq(0, -1);
        #1;
        ntest++;
        if (o_count !== 4'd4 || o_deq_vld !== 4'b1111 || o_deq_inst[3] !== sb[3]) begin
            nfail++;
            $display("FAIL arst_resume: count=%0d vld=%b, want 4 1111",
                     o_count, o_deq_vld);
        end
    endtask

    initial begin
        rst = 1'b0;
        i_squash = 1'b0;
        i_enq_vld = '0;
        i_enq_inst = '0;
        i_deq_rdy = 1'b0;
        i_rob_empty = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_serialize();
        test_wrap();
        test_squash();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
